virtual_ds2431_rom_dispatch: RTL and testbench

VIRTUAL_DS2431_ROM_DISPATCH -- requirements
Module: virtual_ds2431_rom_dispatch

---
 rtl/virtual_ds2431_rom_dispatch.sv | 141 ++++++++++++++
 tb/tb_virtual_ds2431_rom_dispatch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/virtual_ds2431_rom_dispatch.sv
// ROM-command dispatcher for a virtual DS2431 1-Wire slave.
// Decodes the first byte after each bus reset and sequences Read/Match/Skip/Resume ROM.
module virtual_ds2431_rom_dispatch #(
    parameter int unsigned MATCH_LEN = 8
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [63:0] romID,
    input  logic        busReset,
    input  logic [7:0]  rxDat,
    input  logic        rxValid,
    output logic        readRomTrig,
    input  logic        readRomDone,
    output logic        memSel,
    output logic        resumeFlag,
    output logic [7:0]  romCmd,
    output logic        matchFail
);

    localparam int unsigned IdxW = 3;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(MATCH_LEN - 1);

    localparam logic [7:0] CmdReadRom   = 8'h33;
    localparam logic [7:0] CmdSkipRom   = 8'hCC;
    localparam logic [7:0] CmdMatchRom  = 8'h55;
    localparam logic [7:0] CmdResumeRom = 8'hA5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROM_CMD  = 3'd1,
        READ_ROM = 3'd2,
        MATCH    = 3'd3,
        SELECTED = 3'd4,
        HALT     = 3'd5
    } state_t;

    state_t          state;
    state_t          stateNxt;
    logic [IdxW-1:0] byteIdx;
    logic [IdxW-1:0] byteIdxNxt;
    logic            resumeNxt;
    logic [7:0]      romCmdNxt;
    logic            matchFailNxt;
    logic            readRomTrigNxt;
    logic            memSelNxt;
    logic [7:0]      idByte;
    logic            byteHit;

    assign idByte  = romID[{byteIdx, 3'b000} +: 8];
    assign byteHit = (rxDat == idByte);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state       <= IDLE;
            byteIdx     <= '0;
            resumeFlag  <= 1'b0;
            romCmd      <= 8'h00;
            matchFail   <= 1'b0;
            readRomTrig <= 1'b0;
            memSel      <= 1'b0;
        end else begin
            state       <= stateNxt;
            byteIdx     <= byteIdxNxt;
            resumeFlag  <= resumeNxt;
            romCmd      <= romCmdNxt;
            matchFail   <= matchFailNxt;
            readRomTrig <= readRomTrigNxt;
            memSel      <= memSelNxt;
        end
    end

    // Next-state decode; busReset overrides every other event
    always_comb begin
        stateNxt = state;
        if (busReset) begin
            stateNxt = ROM_CMD;
        end else begin
            case (state)
                ROM_CMD: begin
                    if (rxValid) begin
                        case (rxDat)
                            CmdReadRom:   stateNxt = READ_ROM;
                            CmdSkipRom:   stateNxt = SELECTED;
                            CmdMatchRom:  stateNxt = MATCH;
                            CmdResumeRom: stateNxt = resumeFlag ? SELECTED : HALT;
                            default:      stateNxt = HALT;
                        endcase
                    end
                end
                READ_ROM: begin
                    if (readRomDone) stateNxt = SELECTED;
                end
                MATCH: begin
                    if (rxValid) begin
                        if (!byteHit)                stateNxt = HALT;
                        else if (byteIdx == LastIdx) stateNxt = SELECTED;
                    end
                end
                default: stateNxt = state;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        byteIdxNxt     = byteIdx;
        resumeNxt      = resumeFlag;
        romCmdNxt      = romCmd;
        matchFailNxt   = 1'b0;
        readRomTrigNxt = (stateNxt == READ_ROM);
        memSelNxt      = (stateNxt == SELECTED);
        if (busReset) begin
            byteIdxNxt = '0;
        end else begin
            case (state)
                ROM_CMD: begin
                    if (rxValid) begin
                        romCmdNxt  = rxDat;
                        byteIdxNxt = '0;
                        if (rxDat != CmdMatchRom && rxDat != CmdResumeRom) resumeNxt = 1'b0;
                    end
                end
                MATCH: begin
                    if (rxValid) begin
                        if (!byteHit) begin
                            matchFailNxt = 1'b1;
                            resumeNxt    = 1'b0;
                        end else if (byteIdx == LastIdx) begin
                            resumeNxt = 1'b1;
                        end else begin
                            byteIdxNxt = byteIdx + IdxW'(1);
                        end
                    end
                end
                default: byteIdxNxt = byteIdx;
            endcase
        end
    end

endmodule

// File: tb/tb_virtual_ds2431_rom_dispatch.sv
// Self-checking bench: directed scenarios then randomized traffic against a
// behavioural model of the ROM-command layer.
module tb_virtual_ds2431_rom_dispatch;

    logic        clk = 1'b0;
    logic        nRst;
    logic [63:0] romID;
    logic        busReset;
    logic [7:0]  rxDat;
    logic        rxValid;
    logic        readRomTrig;
    logic        readRomDone;
    logic        memSel;
    logic        resumeFlag;
    logic [7:0]  romCmd;
    logic        matchFail;

    int tests = 0;
    int fails = 0;

    // Model: phase of the ROM layer and how many ID bytes have matched so far
    typedef enum int {P_IDLE, P_CMD, P_READ, P_MATCH, P_SEL, P_HALT} phase_t;
    phase_t     mPhase;
    int         mMatched;
    logic       mRc;
    logic [7:0] mCmd;
    logic       mFail;

    virtual_ds2431_rom_dispatch #(.MATCH_LEN(8)) dut (
        .clk(clk), .nRst(nRst), .romID(romID), .busReset(busReset),
        .rxDat(rxDat), .rxValid(rxValid), .readRomTrig(readRomTrig),
        .readRomDone(readRomDone), .memSel(memSel), .resumeFlag(resumeFlag),
        .romCmd(romCmd), .matchFail(matchFail)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] idByteOf(input logic [63:0] id, input int i);
        return 8'((id >> (8 * i)) & 64'hff);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelEdge(input logic r, input logic br, input logic rv,
                             input logic [7:0] d, input logic dn);
        if (!r) begin
            mPhase = P_IDLE; mMatched = 0; mRc = 1'b0; mCmd = 8'h00; mFail = 1'b0;
            return;
        end
        mFail = 1'b0;
        if (br) begin
            mPhase = P_CMD; mMatched = 0;
            return;
        end
        if (mPhase == P_CMD && rv) begin
            mCmd = d;
            if (d == 8'h33)      begin mPhase = P_READ; mRc = 1'b0; end
            else if (d == 8'hCC) begin mPhase = P_SEL;  mRc = 1'b0; end
            else if (d == 8'h55) begin mPhase = P_MATCH; mMatched = 0; end
            else if (d == 8'hA5) mPhase = mRc ? P_SEL : P_HALT;
            else                 begin mPhase = P_HALT; mRc = 1'b0; end
        end else if (mPhase == P_READ && dn) begin
            mPhase = P_SEL;
        end else if (mPhase == P_MATCH && rv) begin
            if (d != idByteOf(romID, mMatched)) begin
                mPhase = P_HALT; mFail = 1'b1; mRc = 1'b0;
            end else begin
                mMatched++;
                if (mMatched == 8) begin mPhase = P_SEL; mRc = 1'b1; end
            end
        end
    endtask

    task automatic step(input logic r, input logic br, input logic rv,
                        input logic [7:0] d, input logic dn);
        nRst = r; busReset = br; rxValid = rv; rxDat = d; readRomDone = dn;
        modelEdge(r, br, rv, d, dn);
        @(posedge clk);
        #1;
        chk("readRomTrig", 8'(readRomTrig), 8'(mPhase == P_READ));
        chk("memSel",      8'(memSel),      8'(mPhase == P_SEL));
        chk("resumeFlag",  8'(resumeFlag),  8'(mRc));
        chk("romCmd",      romCmd,          mCmd);
        chk("matchFail",   8'(matchFail),   8'(mFail));
    endtask

    task automatic sendMatch(input logic [63:0] bytesIn);
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'h55, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, idByteOf(bytesIn, i), 0);
    endtask

    initial begin
        int pick;
        logic r, br, rv, dn;
        logic [7:0] d;

        romID = 64'hc500002c40e4d42d;
        // Reset with noisy inputs
        step(0, 1, 1, 8'h33, 1);
        step(0, 0, 1, 8'hCC, 0);
        chk("rst_romCmd_const", romCmd, 8'h00);
        // IDLE ignores bytes
        step(1, 0, 1, 8'h33, 0);
        step(1, 0, 1, 8'hCC, 0);
        chk("idle_memSel", 8'(memSel), 8'h00);

        // Read ROM
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'h33, 0);
        chk("rd_trig", 8'(readRomTrig), 8'h01);
        step(1, 0, 1, 8'hCC, 0);
        step(1, 0, 0, 8'h00, 1);
        chk("rd_sel", 8'(memSel), 8'h01);
        chk("rd_cmd", romCmd, 8'h33);
        step(1, 0, 1, 8'h55, 0);

        // Match ROM then Resume
        sendMatch(romID);
        chk("match_sel", 8'(memSel), 8'h01);
        chk("match_rc", 8'(resumeFlag), 8'h01);
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'hA5, 0);
        chk("resume_sel", 8'(memSel), 8'h01);

        // Match fail on 4th byte, remaining bytes ignored
        sendMatch({romID[63:32], 8'h41, romID[23:0]});
        chk("fail_memSel", 8'(memSel), 8'h00);
        chk("fail_rc", 8'(resumeFlag), 8'h00);
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'hA5, 0);
        chk("resume_halt", 8'(memSel), 8'h00);

        // busReset during READ_ROM with readRomDone the same cycle
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'h33, 0);
        step(1, 1, 0, 8'h00, 1);
        chk("abort_trig", 8'(readRomTrig), 8'h00);
        step(1, 0, 1, 8'hCC, 0);
        chk("abort_skip", 8'(memSel), 8'h01);

        // busReset beats rxValid in the same cycle
        step(1, 1, 1, 8'h33, 0);
        step(1, 0, 1, 8'h55, 0);
        step(1, 0, 1, 8'h2d, 0);
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'h55, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, idByteOf(romID, i), 0);
        // nRst mid-match, then no activity until busReset
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'h55, 0);
        step(1, 0, 1, 8'h2d, 0);
        step(0, 0, 1, 8'hd4, 0);
        step(1, 0, 1, 8'hCC, 1);
        chk("nrst_memSel", 8'(memSel), 8'h00);
        step(1, 1, 0, 8'h00, 0);
        step(1, 0, 1, 8'hCC, 0);
        chk("skip_rc", 8'(resumeFlag), 8'h00);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) romID = {$urandom, $urandom};
            r  = ($urandom_range(0, 299) != 0);
            br = ($urandom_range(0, 47) == 0);
            rv = ($urandom_range(0, 1) == 0);
            dn = ($urandom_range(0, 3) == 0);
            pick = $urandom_range(0, 9);
            if (mPhase == P_MATCH && pick < 9)
                d = idByteOf(romID, mMatched);
            else begin
                case (pick % 6)
                    0: d = 8'h33;
                    1: d = 8'hCC;
                    2: d = 8'h55;
                    3: d = 8'hA5;
                    4: d = idByteOf(romID, $urandom_range(0, 7));
                    default: d = 8'($urandom);
                endcase
            end
            step(r, br, rv, d, dn);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
